// File: rtl/edge_detection_pkg.sv
// Shared types and constants for the edge-detection datapath.
// Used by the frame controller, the line buffers and the convolution stage.
package edge_detection_pkg;

    localparam int unsigned NUM_LINE_BUFS    = 3;
    localparam int unsigned DEFAULT_MAX_COLS = 1024;
    localparam int unsigned DEFAULT_MAX_ROWS = 768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBLANK,
        ST_ACTIVE,
        ST_HBLANK
    } state_t;

    // Next line buffer in the 0 -> 1 -> 2 -> 0 rotation
    function automatic logic [1:0] next_lb_sel(input logic [1:0] sel);
        return (32'(sel) >= NUM_LINE_BUFS - 1) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage

// File: rtl/edge_detection_frame_ctrl.sv
// Frame/line sequencer: tracks video timing, generates pixel coordinates,
// drives the rotating line-buffer write port and flags complete 3x3 windows.
// Optional per-frame line-length check: define EDGE_DETECTION_LINE_CHECK_EN.
module edge_detection_frame_ctrl
    import edge_detection_pkg::*;
#(
    parameter int unsigned MAX_COLS = DEFAULT_MAX_COLS,
    parameter int unsigned MAX_ROWS = DEFAULT_MAX_ROWS,
    parameter int unsigned COL_W    = $clog2(MAX_COLS),
    parameter int unsigned ROW_W    = $clog2(MAX_ROWS)
) (
    input  logic             I_CORE_CLK,
    input  logic             I_RST,
    input  logic             I_PIX_STB,
    input  logic             I_VSYNC,
    input  logic             I_HSYNC,
    input  logic             I_DE,
    output logic             O_LB_WR_EN,
    output logic [COL_W-1:0] O_LB_WR_ADDR,
    output logic [1:0]       O_LB_SEL,
    output logic [ROW_W-1:0] O_ROW,
    output logic             O_WIN_VALID,
    output logic             O_FRAME_START,
    output logic             O_LINE_END,
    output logic             O_ERR
);

    // Column count is one bit wider so a full line (MAX_COLS pixels) is representable
    localparam int unsigned      CNT_W     = COL_W + 1;
    localparam logic [CNT_W-1:0] COL_LIMIT = CNT_W'(MAX_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(MAX_ROWS - 1);

    state_t           state;
    logic [CNT_W-1:0] col_cnt;
    logic             pix_write_c;
    logic             win_ok_c;
    logic             unused_hsync;

`ifdef EDGE_DETECTION_LINE_CHECK_EN
    logic [CNT_W-1:0] frame_width;
    logic [CNT_W-1:0] line_len;
    logic             first_done;
`endif

    // Sync polarity is carried for observability only; timing uses VSYNC/DE
    assign unused_hsync = I_HSYNC;

    // Pixel accepted this strobe: DE inside a frame and not overridden by VSYNC
    assign pix_write_c = I_PIX_STB && !I_VSYNC && I_DE &&
                         ((state == ST_VBLANK) || (state == ST_HBLANK) || (state == ST_ACTIVE));

    // Two earlier rows and two earlier columns exist, so the 3x3 window is full
    assign win_ok_c = (O_ROW >= ROW_W'(2)) && (col_cnt >= CNT_W'(2));

    // Timing FSM, coordinate counters, buffer rotation and error tracking
    always_ff @(posedge I_CORE_CLK) begin
        if (I_RST) begin
            state         <= ST_IDLE;
            col_cnt       <= '0;
            O_LB_WR_EN    <= 1'b0;
            O_LB_WR_ADDR  <= '0;
            O_LB_SEL      <= '0;
            O_ROW         <= '0;
            O_WIN_VALID   <= 1'b0;
            O_FRAME_START <= 1'b0;
            O_LINE_END    <= 1'b0;
            O_ERR         <= 1'b0;
`ifdef EDGE_DETECTION_LINE_CHECK_EN
            frame_width   <= '0;
            line_len      <= '0;
            first_done    <= 1'b0;
`endif
        end else begin
            O_LB_WR_EN    <= 1'b0;
            O_WIN_VALID   <= 1'b0;
            O_FRAME_START <= 1'b0;
            O_LINE_END    <= 1'b0;

            if (I_PIX_STB) begin
                if (I_VSYNC) begin
                    // Any partial line is dropped without a line-end
                    state <= ST_VSYNC;
                end else begin
                    case (state)
                        ST_VSYNC: begin
                            state         <= ST_VBLANK;
                            O_FRAME_START <= 1'b1;
                            O_ROW         <= '0;
                            O_LB_SEL      <= '0;
                            O_ERR         <= 1'b0;
                            col_cnt       <= '0;
`ifdef EDGE_DETECTION_LINE_CHECK_EN
                            first_done    <= 1'b0;
`endif
                        end
                        ST_VBLANK, ST_HBLANK: begin
                            if (I_DE) begin
                                state <= ST_ACTIVE;
                            end
                        end
                        ST_ACTIVE: begin
                            if (!I_DE) begin
                                state      <= ST_HBLANK;
                                O_LINE_END <= 1'b1;
                                if (O_ROW == ROW_LAST) begin
                                    O_ERR <= 1'b1;
                                end else begin
                                    O_ROW <= O_ROW + ROW_W'(1);
                                end
                                O_LB_SEL <= next_lb_sel(O_LB_SEL);
                                col_cnt  <= '0;
`ifdef EDGE_DETECTION_LINE_CHECK_EN
                                line_len <= col_cnt;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // Line-buffer write; pixels beyond the last column are dropped
            if (pix_write_c) begin
                if (col_cnt < COL_LIMIT) begin
                    O_LB_WR_EN   <= 1'b1;
                    O_LB_WR_ADDR <= COL_W'(col_cnt);
                    O_WIN_VALID  <= win_ok_c;
                    col_cnt      <= col_cnt + CNT_W'(1);
                end else begin
                    O_ERR <= 1'b1;
                end
            end

`ifdef EDGE_DETECTION_LINE_CHECK_EN
            // First line sets the frame width; later lines must match it
            if (O_LINE_END) begin
                if (!first_done) begin
                    frame_width <= line_len;
                    first_done  <= 1'b1;
                end else if (line_len != frame_width) begin
                    O_ERR <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_edge_detection_frame_ctrl.sv
// Self-checking bench for edge_detection_frame_ctrl (MAX_COLS=8, MAX_ROWS=8).
module tb_edge_detection_frame_ctrl;

    localparam int unsigned MAXC = 8;
    localparam int unsigned MAXR = 8;
    localparam int unsigned CW   = 3;
    localparam int unsigned RW   = 3;
`ifdef EDGE_DETECTION_LINE_CHECK_EN
    localparam int EXP_CHK_ERR = 1;
`else
    localparam int EXP_CHK_ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, stb, vs_i, hs_i, de_i;
    logic          wr_en, win, fs, le, err;
    logic [CW-1:0] wr_addr;
    logic [1:0]    lb_sel;
    logic [RW-1:0] row;

    always #5 clk = ~clk;

    edge_detection_frame_ctrl #(.MAX_COLS(MAXC), .MAX_ROWS(MAXR)) dut (
        .I_CORE_CLK   (clk),
        .I_RST        (rst),
        .I_PIX_STB    (stb),
        .I_VSYNC      (vs_i),
        .I_HSYNC      (hs_i),
        .I_DE         (de_i),
        .O_LB_WR_EN   (wr_en),
        .O_LB_WR_ADDR (wr_addr),
        .O_LB_SEL     (lb_sel),
        .O_ROW        (row),
        .O_WIN_VALID  (win),
        .O_FRAME_START(fs),
        .O_LINE_END   (le),
        .O_ERR        (err)
    );

    typedef struct packed {
        logic          wr;
        logic [CW-1:0] addr;
        logic          win;
        logic          fs;
        logic          le;
        logic [RW-1:0] row;
        logic [1:0]    sel;
        logic          err;
    } out_t;

    typedef struct {
        logic vs;
        logic de;
        out_t exp;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    out_t obs_a;
    vec_t tbl[$];

    // Observed-activity statistics for the scenario checks
    int cnt_wr, cnt_win, cnt_le, cnt_fs, max_addr;
    int sel_q[$];

    // Reference model: a frame is "open" after VSYNC falls; a line is open while DE pixels arrive
    typedef enum {M_IDLE, M_VS, M_FRAME} mmode_t;
    mmode_t m_mode;
    bit     m_in_line, m_pend, m_err, m_wr, m_win, m_fs, m_le;
    int     m_col, m_row, m_sel, m_addr, m_width, m_pend_len;

    function automatic out_t model_out();
        out_t o;
        o.wr   = m_wr;
        o.addr = CW'(m_addr);
        o.win  = m_win;
        o.fs   = m_fs;
        o.le   = m_le;
        o.row  = RW'(m_row);
        o.sel  = 2'(m_sel);
        o.err  = m_err;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.wr   = wr_en;
        o.addr = wr_addr;
        o.win  = win;
        o.fs   = fs;
        o.le   = le;
        o.row  = row;
        o.sel  = lb_sel;
        o.err  = err;
        return o;
    endfunction

    function automatic vec_t mk(input bit vs, input bit de, input bit w, input int a,
                                input bit wv, input bit f, input bit l, input int r,
                                input int s, input bit e);
        vec_t v;
        v.vs       = vs;
        v.de       = de;
        v.exp.wr   = w;
        v.exp.addr = CW'(a);
        v.exp.win  = wv;
        v.exp.fs   = f;
        v.exp.le   = l;
        v.exp.row  = RW'(r);
        v.exp.sel  = 2'(s);
        v.exp.err  = e;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_in_line = 0; m_pend = 0; m_err = 0;
        m_wr = 0; m_win = 0; m_fs = 0; m_le = 0;
        m_col = 0; m_row = 0; m_sel = 0; m_addr = 0; m_width = -1; m_pend_len = 0;
    endtask

    task automatic model_step(input bit vs, input bit de);
        m_wr = 0; m_win = 0; m_fs = 0; m_le = 0;
        if (vs) begin
            m_mode    = M_VS;
            m_in_line = 0;
        end else if (m_mode == M_VS) begin
            m_mode = M_FRAME; m_fs = 1; m_row = 0; m_col = 0; m_sel = 0;
            m_err = 0; m_width = -1; m_in_line = 0;
        end else if (m_mode == M_FRAME) begin
            if (de) begin
                m_in_line = 1;
                if (m_col < int'(MAXC)) begin
                    m_wr = 1; m_addr = m_col; m_win = (m_row >= 2) && (m_col >= 2);
                    m_col++;
                end else begin
                    m_err = 1;
                end
            end else if (m_in_line) begin
                m_in_line = 0; m_le = 1;
                if (m_row == int'(MAXR) - 1) m_err = 1;
                else m_row++;
                m_sel = (m_sel + 1) % 3;
                m_pend = 1; m_pend_len = m_col; m_col = 0;
            end
        end
    endtask

    task automatic model_post();
        m_wr = 0; m_win = 0; m_fs = 0; m_le = 0;
        if (m_pend) begin
            m_pend = 0;
`ifdef EDGE_DETECTION_LINE_CHECK_EN
            if (m_width < 0) m_width = m_pend_len;
            else if (m_pend_len != m_width) m_err = 1;
`endif
        end
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got wr=%b addr=%0d win=%b fs=%b le=%b row=%0d sel=%0d err=%b, expected wr=%b addr=%0d win=%b fs=%b le=%b row=%0d sel=%0d err=%b",
                     name, $time, act.wr, act.addr, act.win, act.fs, act.le, act.row, act.sel, act.err,
                     exp.wr, exp.addr, exp.win, exp.fs, exp.le, exp.row, exp.sel, exp.err);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic clr_stats();
        cnt_wr = 0; cnt_win = 0; cnt_le = 0; cnt_fs = 0; max_addr = 0;
        sel_q.delete();
    endtask

    // One pixel strobe followed by one quiet cycle, plus optional extra quiet cycles
    task automatic do_strobe(input bit vs, input bit de, input int gap);
        @(negedge clk);
        stb = 1'b1; vs_i = vs; de_i = de; hs_i = ~de;
        model_step(vs, de);
        @(posedge clk); #1;
        check_out("strobe", model_out());
        obs_a = sample();
        if (obs_a.wr) begin
            cnt_wr++;
            if (int'(obs_a.addr) > max_addr) max_addr = int'(obs_a.addr);
            if (obs_a.addr == '0) sel_q.push_back(int'(obs_a.sel));
        end
        if (obs_a.win) cnt_win++;
        if (obs_a.le)  cnt_le++;
        if (obs_a.fs)  cnt_fs++;
        @(negedge clk);
        stb = 1'b0; de_i = 1'($urandom_range(0, 1));
        model_post();
        @(posedge clk); #1;
        check_out("post", model_out());
        repeat (gap) begin
            @(negedge clk);
            de_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_out("hold", model_out());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stb = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_out("reset", model_out());
        check_int("reset_zero", int'(sample()), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic frame_start();
        do_strobe(1'b1, 1'b0, 0);
        do_strobe(1'b0, 1'b0, 0);
    endtask

    task automatic line(input int n);
        repeat (n) do_strobe(1'b0, 1'b1, 0);
        do_strobe(1'b0, 1'b0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stb = 1'b0; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0;
        model_reset();

        // Idle pixels ignored, then a 3x3 frame, then VSYNC restart
        tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0, 0,0,0,1,0, 0,0,0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1, 1,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1, 1,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1, 1,2,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0, 0,2,0,0,1, 1,1,0));
        tbl.push_back(mk(0,0, 0,2,0,0,0, 1,1,0));
        tbl.push_back(mk(0,1, 1,0,0,0,0, 1,1,0));
        tbl.push_back(mk(0,1, 1,1,0,0,0, 1,1,0));
        tbl.push_back(mk(0,1, 1,2,0,0,0, 1,1,0));
        tbl.push_back(mk(0,0, 0,2,0,0,1, 2,2,0));
        tbl.push_back(mk(0,1, 1,0,0,0,0, 2,2,0));
        tbl.push_back(mk(0,1, 1,1,0,0,0, 2,2,0));
        tbl.push_back(mk(0,1, 1,2,1,0,0, 2,2,0));
        tbl.push_back(mk(0,0, 0,2,0,0,1, 3,0,0));
        tbl.push_back(mk(1,1, 0,2,0,0,0, 3,0,0));
        tbl.push_back(mk(0,0, 0,2,0,1,0, 0,0,0));

        do_reset();
        foreach (tbl[i]) begin
            do_strobe(tbl[i].vs, tbl[i].de, 0);
            n_vec++;
            if (obs_a !== tbl[i].exp) begin
                n_err++;
                $display("FAIL table[%0d]: got %h expected %h", i, obs_a, tbl[i].exp);
            end
        end

        // Full 4x4 frame
        do_reset();
        clr_stats();
        frame_start();
        repeat (4) begin
            line(4);
            do_strobe(1'b0, 1'b0, 0);
        end
        check_int("f4_frame_start", cnt_fs, 1);
        check_int("f4_writes", cnt_wr, 16);
        check_int("f4_max_addr", max_addr, 3);
        check_int("f4_win", cnt_win, 4);
        check_int("f4_line_end", cnt_le, 4);
        check_int("f4_sel_lines", sel_q.size(), 4);
        foreach (sel_q[i]) check_int("f4_sel_seq", sel_q[i], i % 3);
        check_int("f4_err", int'(err), 0);

        // DE pixels before any VSYNC after reset
        do_reset();
        clr_stats();
        repeat (5) do_strobe(1'b0, 1'b1, 0);
        check_int("idle_writes", cnt_wr, 0);
        check_int("idle_outputs", int'(sample()), 0);

        // Over-long line saturates the column
        frame_start();
        clr_stats();
        line(10);
        check_int("long_writes", cnt_wr, 8);
        check_int("long_max_addr", max_addr, 7);
        check_int("long_err", int'(err), 1);
        frame_start();
        check_int("long_err_cleared", int'(err), 0);

        // Line lengths 4,4,3
        line(4);
        line(4);
        repeat (3) do_strobe(1'b0, 1'b1, 0);
        do_strobe(1'b0, 1'b0, 0);
        check_int("chk_line_end", int'(obs_a.le), 1);
        check_int("chk_err_at_le", int'(obs_a.err), 0);
        check_int("chk_err_after", int'(err), EXP_CHK_ERR);

        // VSYNC mid-line at column 2
        frame_start();
        line(4);
        clr_stats();
        repeat (2) do_strobe(1'b0, 1'b1, 0);
        do_strobe(1'b1, 1'b1, 0);
        do_strobe(1'b0, 1'b0, 0);
        check_int("abort_line_end", cnt_le, 0);
        check_int("abort_fs", cnt_fs, 1);
        check_int("abort_row", int'(row), 0);
        check_int("abort_sel", int'(lb_sel), 0);

        // Reset during row 1
        line(3);
        repeat (2) do_strobe(1'b0, 1'b1, 0);
        do_reset();
        clr_stats();
        repeat (3) do_strobe(1'b0, 1'b1, 0);
        check_int("rst_ignored_writes", cnt_wr, 0);
        do_strobe(1'b1, 1'b1, 0);
        do_strobe(1'b0, 1'b1, 0);
        check_int("rst_resume_fs", cnt_fs, 1);
        check_int("rst_resume_no_write", cnt_wr, 0);
        do_strobe(1'b0, 1'b1, 0);
        check_int("rst_resume_write", cnt_wr, 1);

        // Row saturation
        frame_start();
        clr_stats();
        repeat (9) line(1);
        check_int("rowsat_line_end", cnt_le, 9);
        check_int("rowsat_row", int'(row), 7);
        check_int("rowsat_err", int'(err), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                do_strobe(1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 70),
                          int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
